// File: rtl/cnt_seq_ctrl_if.sv
// Command channel between a command source and the counter sequencer.
// Latency: none, wires only.
// Backpressure: cmd_ready from the sequencer gates acceptance of cmd_valid.
interface cnt_seq_ctrl_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_end;
  logic [3:0]   cmd_loops;
  logic         cmd_bounce;

  // Command source side
  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_end,
    output cmd_loops,
    output cmd_bounce,
    input  cmd_ready
  );

  // Sequencer side
  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_end,
    input  cmd_loops,
    input  cmd_bounce,
    output cmd_ready
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Sequencer driving a loadable up/down counter from start to end, with loops and bounce.
// Latency: accept at edge T, load at T+1, one counter step per RUN cycle, done pulse after last leg.
// Backpressure: cmd_ready only in IDLE; pause freezes RUN, abort ends the command at the next edge.
module cnt_seq_ctrl #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cnt_seq_ctrl_if.slave cmd,
  input  logic          pause,
  input  logic          abort,
  input  logic [W-1:0]  cnt_q,
  output logic          cnt_en,
  output logic          cnt_dir,
  output logic          cnt_in,
  output logic [W-1:0]  cnt_data,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    LEG_FWD = 1'b0,
    LEG_RET = 1'b1
  } leg_t;

  state_t       state;
  state_t       state_nxt;
  leg_t         leg;
  leg_t         leg_nxt;
  logic [W-1:0] start_r;
  logic [W-1:0] end_r;
  logic         bounce_r;
  logic [3:0]   loops_left;
  logic [3:0]   loops_nxt;
  logic         accept;
  logic         set_aborted;
  logic [W-1:0] target;

  // The forward leg heads for end, the return leg heads back to start.
  assign target = (leg == LEG_FWD) ? end_r : start_r;

  assign busy          = (state != IDLE);
  assign cmd.cmd_ready = (state == IDLE);

  // State, loop bookkeeping and latched command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      leg        <= LEG_FWD;
      loops_left <= '0;
      start_r    <= '0;
      end_r      <= '0;
      bounce_r   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      leg        <= leg_nxt;
      loops_left <= loops_nxt;
      if (accept) begin
        start_r  <= cmd.cmd_start;
        end_r    <= cmd.cmd_end;
        bounce_r <= cmd.cmd_bounce;
        aborted  <= 1'b0;
      end else if (set_aborted) begin
        aborted  <= 1'b1;
      end
    end
  end

  // Next-state and counter control; cnt_* act on the counter at the same edge.
  always_comb begin
    state_nxt   = state;
    leg_nxt     = leg;
    loops_nxt   = loops_left;
    accept      = 1'b0;
    set_aborted = 1'b0;
    cnt_en      = 1'b0;
    cnt_dir     = 1'b0;
    cnt_in      = 1'b0;
    cnt_data    = '0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          leg_nxt   = LEG_FWD;
          loops_nxt = cmd.cmd_loops;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        // The load goes out even if abort arrives; pause has no effect here.
        cnt_en   = 1'b1;
        cnt_in   = 1'b1;
        cnt_data = start_r;
        if (abort) begin
          set_aborted = 1'b1;
          state_nxt   = DONE;
        end else begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          set_aborted = 1'b1;
          state_nxt   = DONE;
        end else if (pause) begin
          // Everything holds; counter disabled.
        end else if (cnt_q != target) begin
          // Always stepping toward the target, so the counter cannot wrap.
          cnt_en  = 1'b1;
          cnt_dir = (target > cnt_q);
        end else if (bounce_r && (leg == LEG_FWD)) begin
          // Turnaround cycle at the end value.
          leg_nxt = LEG_RET;
        end else if (loops_left == 4'd0) begin
          state_nxt = DONE;
        end else begin
          loops_nxt = loops_left - 4'd1;
          if (bounce_r) begin
            // Return leg already left the counter at start; no reload needed.
            leg_nxt = LEG_FWD;
          end else begin
            state_nxt = LOAD;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

  // A load always enables the counter.
  a_load_en: assert property (@(posedge clk) disable iff (!rst_n) cnt_in |-> cnt_en);

  // Counting steps never cross the wrap boundary.
  a_no_wrap_up: assert property (@(posedge clk) disable iff (!rst_n)
    (cnt_en && !cnt_in && cnt_dir) |-> (cnt_q != {W{1'b1}}));
  a_no_wrap_dn: assert property (@(posedge clk) disable iff (!rst_n)
    (cnt_en && !cnt_in && !cnt_dir) |-> (cnt_q != {W{1'b0}}));

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl with a behavioural 4-bit up/down loadable counter in the loop.
// Inputs and samples happen at the falling edge; cycle k is the value presented at accept edge + k.
module tb_cnt_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt_q = '0;
  logic         cnt_en;
  logic         cnt_dir;
  logic         cnt_in;
  logic [W-1:0] cnt_data;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [9:0]   obs;

  int n_checks = 0;
  int n_pass   = 0;

  cnt_seq_ctrl_if #(.W(W)) cmd_if ();

  cnt_seq_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_if),
    .pause    (pause),
    .abort    (abort),
    .cnt_q    (cnt_q),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .cnt_in   (cnt_in),
    .cnt_data (cnt_data),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  // Counter model: not reset by rst_n, so a reset mid-run leaves its value alone.
  always @(posedge clk) begin
    if (cnt_en) begin
      if (cnt_in)       cnt_q <= cnt_data;
      else if (cnt_dir) cnt_q <= cnt_q + 4'd1;
      else              cnt_q <= cnt_q - 4'd1;
    end
  end

  // {en, dir, in, data, busy, done, ready}
  assign obs = {cnt_en, cnt_dir, cnt_in, cnt_data, busy, done, cmd_if.cmd_ready};

  localparam logic [9:0] O_IDLE = {3'b000, 4'd0, 3'b001};
  localparam logic [9:0] O_UP   = {3'b110, 4'd0, 3'b100};
  localparam logic [9:0] O_DN   = {3'b100, 4'd0, 3'b100};
  localparam logic [9:0] O_HOLD = {3'b000, 4'd0, 3'b100};
  localparam logic [9:0] O_DONE = {3'b000, 4'd0, 3'b110};

  task automatic send(input logic [3:0] s, input logic [3:0] e, input logic [3:0] l, input logic b);
    cmd_if.cmd_start  = s;
    cmd_if.cmd_end    = e;
    cmd_if.cmd_loops  = l;
    cmd_if.cmd_bounce = b;
    cmd_if.cmd_valid  = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] exp_o;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_o = O_IDLE;
    n_checks++;
    if (obs !== exp_o) $display("FAIL reset_outputs got %b want %b", obs, exp_o);
    else n_pass++;
    n_checks++;
    if (aborted !== 1'b0) $display("FAIL reset_aborted got %b want 0", aborted);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [9:0] exp_o;
    send(4'd2, 4'd5, 4'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (k == 1)      exp_o = {3'b101, 4'd2, 3'b100};
      else if (k <= 4) exp_o = O_UP;
      else if (k == 5) exp_o = O_HOLD;
      else if (k == 6) exp_o = O_DONE;
      else             exp_o = O_IDLE;
      n_checks++;
      if (obs !== exp_o) $display("FAIL basic_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if (cnt_q !== 4'(k)) $display("FAIL basic_q k=%0d got %0d want %0d", k, cnt_q, k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] exp_o;
    logic [3:0] exp_q;
    logic       hit_rail;
    hit_rail = 1'b0;
    @(negedge clk);
    send(4'd5, 4'd2, 4'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      exp_q = '0;
      if (k == 1)      exp_o = {3'b101, 4'd5, 3'b100};
      else if (k <= 4) begin exp_o = O_DN;   exp_q = 4'(7 - k); end
      else if (k == 5) begin exp_o = O_HOLD; exp_q = 4'd2;      end
      else if (k <= 8) begin exp_o = O_UP;   exp_q = 4'(k - 4); end
      else if (k == 9) begin exp_o = O_HOLD; exp_q = 4'd5;      end
      else             exp_o = O_DONE;
      n_checks++;
      if (obs !== exp_o) $display("FAIL bounce_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      if (k >= 2 && k <= 9) begin
        n_checks++;
        if (cnt_q !== exp_q) $display("FAIL bounce_q k=%0d got %0d want %0d", k, cnt_q, exp_q);
        else n_pass++;
      end
      if (k >= 2 && (cnt_q == 4'd0 || cnt_q == 4'd15)) hit_rail = 1'b1;
    end
    n_checks++;
    if (hit_rail !== 1'b0) $display("FAIL bounce_rail got %b want 0", hit_rail);
    else n_pass++;
  endtask

  task automatic test_loops();
    logic [9:0] exp_o;
    logic [3:0] exp_q;
    @(negedge clk);
    @(negedge clk);
    send(4'd2, 4'd3, 4'd1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      exp_q = '0;
      case (k)
        1, 4:    exp_o = {3'b101, 4'd2, 3'b100};
        2, 5:    begin exp_o = O_UP;   exp_q = 4'd2; end
        3, 6:    begin exp_o = O_HOLD; exp_q = 4'd3; end
        default: exp_o = O_DONE;
      endcase
      n_checks++;
      if (obs !== exp_o) $display("FAIL loops_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      if (k == 2 || k == 3 || k == 5 || k == 6) begin
        n_checks++;
        if (cnt_q !== exp_q) $display("FAIL loops_q k=%0d got %0d want %0d", k, cnt_q, exp_q);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pause();
    logic [9:0] exp_o;
    logic [3:0] exp_q;
    @(negedge clk);
    @(negedge clk);
    send(4'd0, 4'd15, 4'd0, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      pause = (k >= 6 && k <= 8);
      #1;
      exp_q = '0;
      if (k == 1)       exp_o = {3'b101, 4'd0, 3'b100};
      else if (k <= 5)  begin exp_o = O_UP;   exp_q = 4'(k - 2); end
      else if (k <= 8)  begin exp_o = O_HOLD; exp_q = 4'd4;      end
      else if (k <= 19) begin exp_o = O_UP;   exp_q = 4'(k - 5); end
      else if (k == 20) begin exp_o = O_HOLD; exp_q = 4'd15;     end
      else if (k == 21) exp_o = O_DONE;
      else              exp_o = O_IDLE;
      n_checks++;
      if (obs !== exp_o) $display("FAIL pause_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      if (k >= 2 && k <= 20) begin
        n_checks++;
        if (cnt_q !== exp_q) $display("FAIL pause_q k=%0d got %0d want %0d", k, cnt_q, exp_q);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    logic [9:0] exp_o;
    send(4'd0, 4'd12, 4'd0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      abort = (k == 9);
      #1;
      if (k == 1)       exp_o = {3'b101, 4'd0, 3'b100};
      else if (k <= 8)  exp_o = O_UP;
      else if (k == 9)  exp_o = O_HOLD;
      else if (k == 10) exp_o = O_DONE;
      else              exp_o = O_IDLE;
      n_checks++;
      if (obs !== exp_o) $display("FAIL abort_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      if (k >= 9) begin
        n_checks++;
        if (cnt_q !== 4'd7) $display("FAIL abort_q k=%0d got %0d want 7", k, cnt_q);
        else n_pass++;
        n_checks++;
        if (aborted !== (k >= 10)) $display("FAIL abort_flag k=%0d got %b want %b", k, aborted, (k >= 10));
        else n_pass++;
      end
    end
    // Follow-up command clears aborted on accept.
    send(4'd3, 4'd4, 4'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      #1;
      if (k == 1)      exp_o = {3'b101, 4'd3, 3'b100};
      else if (k == 2) exp_o = O_UP;
      else if (k == 3) exp_o = O_HOLD;
      else             exp_o = O_DONE;
      n_checks++;
      if (obs !== exp_o) $display("FAIL abort_next_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
      n_checks++;
      if (aborted !== 1'b0) $display("FAIL abort_clear k=%0d got %b want 0", k, aborted);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] exp_o;
    @(negedge clk);
    @(negedge clk);
    send(4'd1, 4'd9, 4'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) cmd_if.cmd_valid = 1'b0;
      if (k == 4) rst_n = 1'b0;
      #1;
      if (k >= 4) begin
        n_checks++;
        if (obs !== O_IDLE) $display("FAIL rst_mid_ctl k=%0d got %b want %b", k, obs, O_IDLE);
        else n_pass++;
        n_checks++;
        if (cnt_q !== 4'd3) $display("FAIL rst_mid_q k=%0d got %0d want 3", k, cnt_q);
        else n_pass++;
      end
      if (k == 5) rst_n = 1'b1;
    end
    // Command held high across DONE is only taken at the following IDLE edge.
    send(4'd6, 4'd6, 4'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) cmd_if.cmd_valid = 1'b0;
      #1;
      case (k)
        1, 5:    exp_o = {3'b101, 4'd6, 3'b100};
        2, 6:    exp_o = O_HOLD;
        3, 7:    exp_o = O_DONE;
        default: exp_o = O_IDLE;
      endcase
      n_checks++;
      if (obs !== exp_o) $display("FAIL held_cmd_ctl k=%0d got %b want %b", k, obs, exp_o);
      else n_pass++;
    end
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_start  = '0;
    cmd_if.cmd_end    = '0;
    cmd_if.cmd_loops  = '0;
    cmd_if.cmd_bounce = 1'b0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_bounce();
    test_loops();
    test_pause();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
